spi_pin_conditioner: RTL and testbench

//  SPI slave front end. Takes raw asynchronous SCLK, CS and MOSI pins and delivers clean,
//  clk-synchronous signals to the SPI memory FSM, shift register and address latch.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/input_conditioner.sv | 103 ++++++++++
 rtl/spi_pin_conditioner.sv | 85 ++++++++
 tb/tb_spi_pin_conditioner.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave front end: the default debounce wait,
// the idle (deselected) level of chip select, and the encoding of the
// per-channel conditioner phase.
// -----------------------------------------------------------------------------
package spi_pkg;

   // Extra clk cycles a pin mismatch must persist before it is accepted.
   localparam int WAIT_TIME_DEF = 3;

   // Chip select is active low, so the idle/deselected level is 1.
   localparam logic CS_IDLE = 1'b1;

   // STABLE  : synchronized pin agrees with the conditioned level.
   // SETTLING: synchronized pin disagrees and the wait counter is running.
   typedef enum logic {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } cond_state_e;

endpackage

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// One channel of pin conditioning: a 2-flop synchronizer followed by a
// debouncer that only accepts a new level once the synchronized pin has
// disagreed with the conditioned level for WAIT_TIME+1 consecutive clk cycles.
// Edge strobes are registered alongside the conditioned level, so a strobe and
// the new level become visible in the same cycle and last exactly one clk.
//
// Parameters
//   WAIT_TIME    extra cycles a mismatch must persist (0 = accept after one)
//   RST_VAL      reset value of the synchronizer and the conditioned level
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   noisysignal  in   raw asynchronous pin
//   conditioned  out  synchronized, debounced level
//   positiveedge out  one-clk strobe when conditioned goes 0->1
//   negativedge  out  one-clk strobe when conditioned goes 1->0
// -----------------------------------------------------------------------------
module input_conditioner
   import spi_pkg::*;
#(
   parameter int   WAIT_TIME = WAIT_TIME_DEF,
   parameter logic RST_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic noisysignal,
   output logic conditioned,
   output logic positiveedge,
   output logic negativedge
);

   // A zero-wait configuration still needs a 1-bit counter to keep the
   // declarations legal; it is never incremented in that case.
   localparam int CNT_W = (WAIT_TIME < 1) ? 1 : $clog2(WAIT_TIME + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIME);

   logic             sync1;
   logic             sync2;
   logic             cond;
   logic [CNT_W-1:0] count;
   logic             pos;
   logic             neg;

   cond_state_e      state;
   logic             cond_next;
   logic [CNT_W-1:0] count_next;
   logic             pos_next;
   logic             neg_next;

   // Phase is implied by whether the synchronized pin matches the output.
   always_comb begin
      state      = (sync2 == cond) ? STABLE : SETTLING;
      cond_next  = cond;
      count_next = '0;
      pos_next   = 1'b0;
      neg_next   = 1'b0;
      case (state)
         STABLE: begin
            // A glitch that returned before acceptance lands here and
            // simply clears the counter without touching the output.
            count_next = '0;
         end
         SETTLING: begin
            if (count == CNT_MAX) begin
               cond_next = sync2;
               pos_next  = sync2;
               neg_next  = ~sync2;
            end else begin
               count_next = count + CNT_W'(1);
            end
         end
         default: begin
            count_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
         cond  <= RST_VAL;
         count <= '0;
         pos   <= 1'b0;
         neg   <= 1'b0;
      end else begin
         // Plain flop-to-flop synchronizer, no logic between the stages.
         sync1 <= noisysignal;
         sync2 <= sync1;
         cond  <= cond_next;
         count <= count_next;
         pos   <= pos_next;
         neg   <= neg_next;
      end
   end

   assign conditioned  = cond;
   assign positiveedge = pos;
   assign negativedge  = neg;

endmodule

// File: rtl/spi_pin_conditioner.sv
// -----------------------------------------------------------------------------
// spi_pin_conditioner
// SPI slave front end. Turns the raw asynchronous SCLK, CS and MOSI pins into
// clean clk-synchronous levels plus one-clk edge strobes for the SPI memory
// FSM, the shift register and the address latch. The three channels are
// independent; simultaneous CS and SCLK strobes are left for the FSM to order.
//
// Parameters
//   WAIT_TIME    extra cycles a pin change must persist before acceptance
//   CS_RST       reset/idle level of csCond (deselected)
//   SCLK_RST     reset level of sclkCond
//   MOSI_RST     reset level of mosiCond
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   sclk_pin     in   raw SPI clock pin
//   cs_pin       in   raw chip-select pin, active low
//   mosi_pin     in   raw serial data-in pin
//   sclkCond     out  conditioned SCLK level
//   sclkPosEdge  out  one-clk strobe on sclkCond 0->1 (FSM perEdge, shift-in)
//   sclkNegEdge  out  one-clk strobe on sclkCond 1->0 (MISO shift-out)
//   csCond       out  conditioned CS level (FSM chipSelect)
//   csNegEdge    out  one-clk strobe on csCond 1->0 (transaction start)
//   mosiCond     out  conditioned MOSI level (shift-register serial in)
// -----------------------------------------------------------------------------
module spi_pin_conditioner
   import spi_pkg::*;
#(
   parameter int   WAIT_TIME = WAIT_TIME_DEF,
   parameter logic CS_RST    = CS_IDLE,
   parameter logic SCLK_RST  = 1'b0,
   parameter logic MOSI_RST  = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sclk_pin,
   input  logic cs_pin,
   input  logic mosi_pin,
   output logic sclkCond,
   output logic sclkPosEdge,
   output logic sclkNegEdge,
   output logic csCond,
   output logic csNegEdge,
   output logic mosiCond
);

   input_conditioner #(
      .WAIT_TIME (WAIT_TIME),
      .RST_VAL   (SCLK_RST)
   ) u_sclk (
      .clk          (clk),
      .reset_n      (reset_n),
      .noisysignal  (sclk_pin),
      .conditioned  (sclkCond),
      .positiveedge (sclkPosEdge),
      .negativedge  (sclkNegEdge)
   );

   // Only the falling edge of CS (selection) is of interest downstream.
   input_conditioner #(
      .WAIT_TIME (WAIT_TIME),
      .RST_VAL   (CS_RST)
   ) u_cs (
      .clk          (clk),
      .reset_n      (reset_n),
      .noisysignal  (cs_pin),
      .conditioned  (csCond),
      .positiveedge (),
      .negativedge  (csNegEdge)
   );

   // MOSI is sampled on SCLK strobes, so its own edges are not needed.
   input_conditioner #(
      .WAIT_TIME (WAIT_TIME),
      .RST_VAL   (MOSI_RST)
   ) u_mosi (
      .clk          (clk),
      .reset_n      (reset_n),
      .noisysignal  (mosi_pin),
      .conditioned  (mosiCond),
      .positiveedge (),
      .negativedge  ()
   );

endmodule

// File: tb/tb_spi_pin_conditioner.sv
// -----------------------------------------------------------------------------
// tb_spi_pin_conditioner
// Drives two conditioners (WAIT_TIME=3 and WAIT_TIME=0) from the same pins and
// compares every output, every cycle, against a reference model: each output
// level follows the pin as seen two clk samples late, but only once that
// delayed pin has disagreed with the output for WAIT_TIME+1 cycles in a row.
// -----------------------------------------------------------------------------
module tb_spi_pin_conditioner;

   localparam logic [2:0] RSTV = 3'b001;   // {mosi, sclk, cs} reset levels

   logic clk = 1'b0;
   logic reset_n;
   logic sclk_pin, cs_pin, mosi_pin;

   logic sc0, sp0, sn0, cc0, cn0, mc0;
   logic sc1, sp1, sn1, cc1, cn1, mc1;

   int errors = 0;
   int checks = 0;

   // Model state per DUT (0: WAIT_TIME=3, 1: WAIT_TIME=0); bit 0 cs, 1 sclk, 2 mosi.
   logic [2:0] m_h1[2], m_h2[2], m_cond[2], m_pos[2], m_neg[2];
   int         m_run[2][3];
   int         wt[2] = '{3, 0};

   int          n_pos[2], n_neg[2], n_csn[2], n_mrise[2];
   logic [15:0] cap[2];
   logic        m_prev[2];

   always #5 clk = ~clk;

   spi_pin_conditioner #(.WAIT_TIME(3)) dut (
      .clk(clk), .reset_n(reset_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
      .sclkCond(sc0), .sclkPosEdge(sp0), .sclkNegEdge(sn0),
      .csCond(cc0), .csNegEdge(cn0), .mosiCond(mc0)
   );

   spi_pin_conditioner #(.WAIT_TIME(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
      .sclkCond(sc1), .sclkPosEdge(sp1), .sclkNegEdge(sn1),
      .csCond(cc1), .csNegEdge(cn1), .mosiCond(mc1)
   );

   // {csNegEdge, sclkNegEdge, sclkPosEdge, mosiCond, sclkCond, csCond}
   function automatic logic [5:0] obs(input int d);
      if (d == 0) return {cn0, sn0, sp0, mc0, sc0, cc0};
      return {cn1, sn1, sp1, mc1, sc1, cc1};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_h1[d] = RSTV; m_h2[d] = RSTV; m_cond[d] = RSTV;
         m_pos[d] = '0;  m_neg[d] = '0;
         for (int ch = 0; ch < 3; ch++) m_run[d][ch] = 0;
      end
   endtask

   task automatic model_edge();
      logic [2:0] pins, seen;
      pins = {mosi_pin, sclk_pin, cs_pin};
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         seen     = m_h2[d];
         m_h2[d]  = m_h1[d];
         m_h1[d]  = pins;
         m_pos[d] = '0;
         m_neg[d] = '0;
         for (int ch = 0; ch < 3; ch++) begin
            if (seen[ch] != m_cond[d][ch]) begin
               m_run[d][ch] = m_run[d][ch] + 1;
               if (m_run[d][ch] == wt[d] + 1) begin
                  m_cond[d][ch] = seen[ch];
                  if (seen[ch]) m_pos[d][ch] = 1'b1;
                  else          m_neg[d][ch] = 1'b1;
                  m_run[d][ch] = 0;
               end
            end else begin
               m_run[d][ch] = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [5:0] o;
      string      t;
      for (int d = 0; d < 2; d++) begin
         o = obs(d);
         t = (d == 0) ? "wt3" : "wt0";
         check({t, "_csCond"},      32'(o[0]), 32'(m_cond[d][0]));
         check({t, "_sclkCond"},    32'(o[1]), 32'(m_cond[d][1]));
         check({t, "_mosiCond"},    32'(o[2]), 32'(m_cond[d][2]));
         check({t, "_sclkPosEdge"}, 32'(o[3]), 32'(m_pos[d][1]));
         check({t, "_sclkNegEdge"}, 32'(o[4]), 32'(m_neg[d][1]));
         check({t, "_csNegEdge"},   32'(o[5]), 32'(m_neg[d][0]));
      end
   endtask

   task automatic clear_counts();
      for (int d = 0; d < 2; d++) begin
         n_pos[d] = 0; n_neg[d] = 0; n_csn[d] = 0; n_mrise[d] = 0; cap[d] = '0;
      end
   endtask

   task automatic tick();
      logic [5:0] o;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      for (int d = 0; d < 2; d++) begin
         o = obs(d);
         if (o[3]) begin
            n_pos[d]++;
            cap[d] = {cap[d][14:0], o[2]};
         end
         if (o[4]) n_neg[d]++;
         if (o[5]) n_csn[d]++;
         if (!m_prev[d] && o[2]) n_mrise[d]++;
         m_prev[d] = o[2];
      end
   endtask

   initial begin
      int          hold[3];
      int          first;
      logic [15:0] pattern;
      logic [5:0]  o;

      reset_n = 1'b0;
      cs_pin = 1'b1; sclk_pin = 1'b0; mosi_pin = 1'b0;
      model_reset();
      m_prev = '{1'b0, 1'b0};
      clear_counts();

      // Reset held with pins toggling.
      repeat (6) begin
         cs_pin = 1'($urandom); sclk_pin = 1'($urandom); mosi_pin = 1'($urandom);
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         o = obs(d);
         check("rst_csCond", 32'(o[0]), 32'd1);
         check("rst_sclkCond", 32'(o[1]), 32'd0);
         check("rst_mosiCond", 32'(o[2]), 32'd0);
         check("rst_pulses", 32'(o[5:3]), 32'd0);
      end
      cs_pin = 1'b1; sclk_pin = 1'b0; mosi_pin = 1'b0;
      tick();
      reset_n = 1'b1;
      clear_counts();
      repeat (10) tick();
      for (int d = 0; d < 2; d++)
         check("release_no_pulse", 32'(n_pos[d] + n_neg[d] + n_csn[d]), 32'd0);

      // Clean SCLK rise then fall.
      for (int dir = 1; dir >= 0; dir--) begin
         sclk_pin = 1'(dir);
         for (int t = 1; t <= 8; t++) begin
            tick();
            o = obs(0);
            if (t == 5) check("edge_wt3_before", 32'(o[1]), 32'(1 - dir));
            if (t == 6) begin
               check("edge_wt3_level", 32'(o[1]), 32'(dir));
               check("edge_wt3_strobe", 32'(dir ? o[3] : o[4]), 32'd1);
            end
            if (t == 7) check("edge_wt3_width", 32'(o[4:3]), 32'd0);
            o = obs(1);
            if (t == 2) check("edge_wt0_before", 32'(o[1]), 32'(1 - dir));
            if (t == 3) begin
               check("edge_wt0_level", 32'(o[1]), 32'(dir));
               check("edge_wt0_strobe", 32'(dir ? o[3] : o[4]), 32'd1);
            end
            if (t == 4) check("edge_wt0_width", 32'(o[4:3]), 32'd0);
         end
      end

      // CS glitch of 3 clk rejected, 4 clk accepted.
      clear_counts();
      cs_pin = 1'b0; repeat (3) tick();
      cs_pin = 1'b1; repeat (10) tick();
      check("glitch3_csNegEdge", 32'(n_csn[0]), 32'd0);
      check("glitch3_csCond", 32'(cc0), 32'd1);
      clear_counts();
      cs_pin = 1'b0; repeat (4) tick();
      cs_pin = 1'b1; repeat (10) tick();
      check("glitch4_csNegEdge", 32'(n_csn[0]), 32'd1);

      // MOSI bouncing, then steady high.
      clear_counts();
      for (int i = 0; i < 4; i++) begin
         mosi_pin = 1'((i + 1) % 2);
         repeat (2) tick();
      end
      check("bounce_held_low", 32'(n_mrise[0]), 32'd0);
      mosi_pin = 1'b1;
      first = -1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (mc0 && first < 0) first = t;
      end
      check("bounce_rises", 32'(n_mrise[0]), 32'd1);
      check("bounce_latency", 32'(first), 32'd6);

      // Reset in the middle of an SCLK debounce.
      sclk_pin = 1'b1;
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      check("midrst_sclkCond", 32'(sc0), 32'd0);
      reset_n = 1'b1;
      first = -1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (sc0 && first < 0) first = t;
      end
      check("midrst_reaccept", 32'(first), 32'd6);
      sclk_pin = 1'b0;
      repeat (10) tick();

      // SPI frame: 16 SCLK cycles with half-period 8 clk, data 0xA5 0x3C.
      pattern = 16'hA53C;
      clear_counts();
      cs_pin = 1'b0;
      repeat (10) tick();
      for (int b = 15; b >= 0; b--) begin
         mosi_pin = pattern[b];
         sclk_pin = 1'b0;
         repeat (8) tick();
         sclk_pin = 1'b1;
         repeat (8) tick();
      end
      sclk_pin = 1'b0;
      repeat (10) tick();
      cs_pin = 1'b1;
      repeat (10) tick();
      for (int d = 0; d < 2; d++) begin
         check("frame_posedges", 32'(n_pos[d]), 32'd16);
         check("frame_negedges", 32'(n_neg[d]), 32'd16);
         check("frame_csNegEdge", 32'(n_csn[d]), 32'd1);
         check("frame_mosi_data", 32'(cap[d]), 32'hA53C);
      end

      // Random pin activity with random hold lengths and occasional resets.
      hold = '{1, 1, 1};
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < 3; ch++) begin
            hold[ch]--;
            if (hold[ch] <= 0) begin
               hold[ch] = int'($urandom_range(1, 9));
               case (ch)
                  0: cs_pin = ~cs_pin;
                  1: sclk_pin = ~sclk_pin;
                  default: mosi_pin = ~mosi_pin;
               endcase
            end
         end
         if ($urandom_range(0, 399) == 0) begin
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
